// File: rtl/bpu_pkg.sv
// Shared types and helpers for the 2-bit branch prediction unit.
package bpu_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    STK = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = WNT;
  localparam ctr_t CTR_ALLOC = WT;

  typedef enum logic [1:0] {
    WR_NONE  = 2'b00,
    WR_TRAIN = 2'b01,
    WR_INVAL = 2'b10
  } wr_op_t;

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
    case (ctr)
      SNT:     sat_update = taken ? WNT : SNT;
      WNT:     sat_update = taken ? WT  : SNT;
      WT:      sat_update = taken ? STK : WNT;
      default: sat_update = taken ? STK : WT;
    endcase
  endfunction

endpackage

// File: rtl/bpu_btb_table.sv
// Direct-mapped BTB storage: one combinational read port for fetch and one
// synchronous training/invalidate write port for branch resolution.
module bpu_btb_table
  import bpu_pkg::*;
#(
  parameter int unsigned IDX_BITS = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [IDX_BITS-1:0]       i_rd_idx,
  input  logic [30-IDX_BITS-1:0]    i_rd_tag,
  output logic                      o_rd_hit,
  output ctr_t                      o_rd_ctr,
  output logic [31:0]               o_rd_target,
  input  wr_op_t                    i_wr_op,
  input  logic [IDX_BITS-1:0]       i_wr_idx,
  input  logic [30-IDX_BITS-1:0]    i_wr_tag,
  input  logic                      i_wr_taken,
  input  logic [31:0]               i_wr_target
);

  localparam int unsigned DEPTH    = 1 << IDX_BITS;
  localparam int unsigned TAG_BITS = 30 - IDX_BITS;

  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q    [DEPTH];
  logic [TAG_BITS-1:0] tag_d    [DEPTH];
  logic [31:0]         target_q [DEPTH];
  logic [31:0]         target_d [DEPTH];
  ctr_t                ctr_q    [DEPTH];
  ctr_t                ctr_d    [DEPTH];

  logic wr_hit;

  // Read port returns pre-update contents; no write bypass.
  always_comb begin
    o_rd_hit    = valid_q[i_rd_idx] && (tag_q[i_rd_idx] == i_rd_tag);
    o_rd_ctr    = ctr_q[i_rd_idx];
    o_rd_target = target_q[i_rd_idx];
  end

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    wr_hit   = valid_q[i_wr_idx] && (tag_q[i_wr_idx] == i_wr_tag);
    case (i_wr_op)
      WR_TRAIN: begin
        if (wr_hit) begin
          ctr_d[i_wr_idx] = sat_update(ctr_q[i_wr_idx], i_wr_taken);
          if (i_wr_taken) begin
            target_d[i_wr_idx] = i_wr_target;
          end
        end else if (i_wr_taken) begin
          valid_d[i_wr_idx]  = 1'b1;
          tag_d[i_wr_idx]    = i_wr_tag;
          target_d[i_wr_idx] = i_wr_target;
          ctr_d[i_wr_idx]    = CTR_ALLOC;
        end
      end
      WR_INVAL: valid_d[i_wr_idx] = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RESET;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

endmodule

// File: rtl/bpu_2bit.sv
// Fetch-stage branch predictor: BTB lookup, EX-stage mispredict detection,
// stall-tolerant redirect, next-PC selection and branch statistics.
module bpu_2bit
  import bpu_pkg::*;
#(
  parameter int unsigned IDX_BITS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic [31:0] i_if_pc,
  output logic        o_if_pred_taken,
  output logic [31:0] o_if_pred_target,
  output logic [31:0] o_next_pc,
  input  logic        i_ex_valid,
  input  logic        i_ex_is_branch,
  input  logic [31:0] i_ex_pc,
  input  logic        i_ex_pred_taken,
  input  logic [31:0] i_ex_pred_target,
  input  logic        i_ex_taken,
  input  logic [31:0] i_ex_target,
  output logic        o_flush,
  output logic [31:0] o_branch_cnt,
  output logic [31:0] o_mispred_cnt
);

  localparam int unsigned TAG_BITS = 30 - IDX_BITS;

  logic                rd_hit;
  ctr_t                rd_ctr;
  logic [31:0]         rd_target;
  wr_op_t              wr_op;
  logic                mis;
  logic [31:0]         correct_pc;
  logic                pend_vld_q, pend_vld_d;
  logic [31:0]         pend_pc_q, pend_pc_d;
  logic [31:0]         branch_cnt_q, branch_cnt_d;
  logic [31:0]         mispred_cnt_q, mispred_cnt_d;

  bpu_btb_table #(.IDX_BITS(IDX_BITS)) u_table (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rd_idx    (i_if_pc[IDX_BITS+1:2]),
    .i_rd_tag    (i_if_pc[31:IDX_BITS+2]),
    .o_rd_hit    (rd_hit),
    .o_rd_ctr    (rd_ctr),
    .o_rd_target (rd_target),
    .i_wr_op     (wr_op),
    .i_wr_idx    (i_ex_pc[IDX_BITS+1:2]),
    .i_wr_tag    (TAG_BITS'(i_ex_pc[31:IDX_BITS+2])),
    .i_wr_taken  (i_ex_taken),
    .i_wr_target (i_ex_target)
  );

  // Mispredict classes: wrong direction, wrong taken target, non-branch alias.
  always_comb begin
    mis = i_ex_valid &&
          ((i_ex_is_branch && (i_ex_pred_taken != i_ex_taken)) ||
           (i_ex_is_branch && i_ex_taken && i_ex_pred_taken &&
            (i_ex_pred_target != i_ex_target)) ||
           (!i_ex_is_branch && i_ex_pred_taken));
    correct_pc = (i_ex_is_branch && i_ex_taken) ? i_ex_target : 32'(i_ex_pc + 32'd4);

    wr_op = WR_NONE;
    if (i_ex_valid && i_ex_is_branch) begin
      wr_op = WR_TRAIN;
    end else if (i_ex_valid && i_ex_pred_taken) begin
      wr_op = WR_INVAL;
    end
  end

  // A redirect found under stall is parked until the front end can accept it.
  always_comb begin
    pend_vld_d    = pend_vld_q;
    pend_pc_d     = pend_pc_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (mis && i_stall) begin
      pend_vld_d = 1'b1;
      pend_pc_d  = correct_pc;
    end else if (!i_stall) begin
      pend_vld_d = 1'b0;
    end
    if (i_ex_valid && i_ex_is_branch) begin
      branch_cnt_d = 32'(branch_cnt_q + 32'd1);
    end
    if (mis) begin
      mispred_cnt_d = 32'(mispred_cnt_q + 32'd1);
    end
  end

  always_comb begin
    o_if_pred_taken  = rd_hit && rd_ctr[1];
    o_if_pred_target = rd_hit ? rd_target : 32'd0;
    o_flush          = !i_stall && (mis || pend_vld_q);
    if (mis && !i_stall) begin
      o_next_pc = correct_pc;
    end else if (pend_vld_q && !i_stall) begin
      o_next_pc = pend_pc_q;
    end else if (o_if_pred_taken) begin
      o_next_pc = o_if_pred_target;
    end else begin
      o_next_pc = 32'(i_if_pc + 32'd4);
    end
    o_branch_cnt  = branch_cnt_q;
    o_mispred_cnt = mispred_cnt_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_vld_q    <= 1'b0;
      pend_pc_q     <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      pend_vld_q    <= pend_vld_d;
      pend_pc_q     <= pend_pc_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

endmodule

// File: tb/tb_bpu_2bit.sv
// Self-checking bench for bpu_2bit: directed scenarios followed by random
// traffic, all compared against a table-of-integers reference model.
module tb_bpu_2bit;

  logic        clk = 1'b0;
  logic        i_rst, i_stall;
  logic [31:0] i_if_pc;
  logic        o_if_pred_taken;
  logic [31:0] o_if_pred_target, o_next_pc;
  logic        i_ex_valid, i_ex_is_branch, i_ex_pred_taken, i_ex_taken;
  logic [31:0] i_ex_pc, i_ex_pred_target, i_ex_target;
  logic        o_flush;
  logic [31:0] o_branch_cnt, o_mispred_cnt;

  always #5 clk = ~clk;

  bpu_2bit #(.IDX_BITS(4)) dut (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .i_stall         (i_stall),
    .i_if_pc         (i_if_pc),
    .o_if_pred_taken (o_if_pred_taken),
    .o_if_pred_target(o_if_pred_target),
    .o_next_pc       (o_next_pc),
    .i_ex_valid      (i_ex_valid),
    .i_ex_is_branch  (i_ex_is_branch),
    .i_ex_pc         (i_ex_pc),
    .i_ex_pred_taken (i_ex_pred_taken),
    .i_ex_pred_target(i_ex_pred_target),
    .i_ex_taken      (i_ex_taken),
    .i_ex_target     (i_ex_target),
    .o_flush         (o_flush),
    .o_branch_cnt    (o_branch_cnt),
    .o_mispred_cnt   (o_mispred_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: 16 entries, counter kept as an integer 0..3.
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  bit          m_pend;
  logic [31:0] m_pend_pc;
  logic [31:0] m_bcnt, m_mcnt;

  logic        obs_pt, obs_flush;
  logic [31:0] obs_tgt, obs_next, obs_mcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 1;
    end
    m_pend    = 0;
    m_pend_pc = '0;
    m_bcnt    = '0;
    m_mcnt    = '0;
  endtask

  task automatic idle_inputs();
    i_stall = 0; i_if_pc = 32'h0; i_ex_valid = 0; i_ex_is_branch = 0;
    i_ex_pc = 32'h0; i_ex_pred_taken = 0; i_ex_pred_target = 32'h0;
    i_ex_taken = 0; i_ex_target = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
    model_reset();
  endtask

  // One clock: drive, check combinational outputs, clock, advance model.
  task automatic cycle(input bit stall, input logic [31:0] if_pc, input bit ev, input bit br,
                       input logic [31:0] epc, input bit pt, input logic [31:0] ptgt,
                       input bit tk, input logic [31:0] tgt);
    int          idx, eidx;
    bit          hit, e_pt, mis, e_flush, e_hit;
    logic [31:0] e_ptgt, corr, e_next;
    i_stall = stall; i_if_pc = if_pc; i_ex_valid = ev; i_ex_is_branch = br;
    i_ex_pc = epc; i_ex_pred_taken = pt; i_ex_pred_target = ptgt;
    i_ex_taken = tk; i_ex_target = tgt;
    #2;
    idx    = int'(if_pc[5:2]);
    hit    = m_valid[idx] && (m_tag[idx] == if_pc[31:6]);
    e_pt   = hit && (m_ctr[idx] >= 2);
    e_ptgt = hit ? m_tgt[idx] : 32'h0;
    mis    = ev && ((br && pt != tk) || (br && tk && pt && ptgt != tgt) || (!br && pt));
    corr   = (br && tk) ? tgt : epc + 32'd4;
    e_flush = !stall && (mis || m_pend);
    e_next = mis ? corr : (m_pend ? m_pend_pc : (e_pt ? e_ptgt : if_pc + 32'd4));
    obs_pt = o_if_pred_taken; obs_tgt = o_if_pred_target; obs_flush = o_flush;
    obs_next = o_next_pc; obs_mcnt = o_mispred_cnt;
    chk("pred_taken",  32'(obs_pt), 32'(e_pt));
    chk("pred_target", obs_tgt, e_ptgt);
    chk("flush",       32'(obs_flush), 32'(e_flush));
    if (!stall) chk("next_pc", obs_next, e_next);
    chk("branch_cnt",  o_branch_cnt, m_bcnt);
    chk("mispred_cnt", obs_mcnt, m_mcnt);
    @(posedge clk);
    eidx  = int'(epc[5:2]);
    e_hit = m_valid[eidx] && (m_tag[eidx] == epc[31:6]);
    if (ev && br) begin
      m_bcnt = m_bcnt + 32'd1;
      if (e_hit) begin
        m_ctr[eidx] = tk ? ((m_ctr[eidx] == 3) ? 3 : m_ctr[eidx] + 1)
                         : ((m_ctr[eidx] == 0) ? 0 : m_ctr[eidx] - 1);
        if (tk) m_tgt[eidx] = tgt;
      end else if (tk) begin
        m_valid[eidx] = 1; m_tag[eidx] = epc[31:6]; m_tgt[eidx] = tgt; m_ctr[eidx] = 2;
      end
    end else if (ev && pt) begin
      m_valid[eidx] = 0;
    end
    if (mis) m_mcnt = m_mcnt + 32'd1;
    if (mis && stall) begin
      m_pend = 1; m_pend_pc = corr;
    end else if (!stall) begin
      m_pend = 0;
    end
    #1;
  endtask

  function automatic logic [31:0] mkpc();
    return 32'h1000 | (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2);
  endfunction

  initial begin
    logic [31:0] rpc, rtg;
    do_reset();

    cycle(0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    chk("tp_reset_pred", 32'(obs_pt), 32'd0);
    chk("tp_reset_next", obs_next, 32'h104);
    chk("tp_reset_flush", 32'(obs_flush), 32'd0);
    cycle(0, 32'h100, 1, 1, 32'h100, 0, 0, 1, 32'h200);
    chk("tp_first_flush", 32'(obs_flush), 32'd1);
    chk("tp_first_next", obs_next, 32'h200);
    cycle(0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    chk("tp_learn_pred", 32'(obs_pt), 32'd1);
    chk("tp_learn_tgt", obs_tgt, 32'h200);
    chk("tp_mcnt_one", obs_mcnt, 32'd1);
    cycle(0, 32'h104, 1, 1, 32'h100, 1, 32'h200, 1, 32'h200);
    cycle(0, 32'h104, 1, 1, 32'h100, 1, 32'h200, 0, 0);
    cycle(0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    chk("tp_weak_t_pred", 32'(obs_pt), 32'd1);
    cycle(0, 32'h104, 1, 1, 32'h100, 1, 32'h200, 0, 0);
    cycle(0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    chk("tp_weak_nt_pred", 32'(obs_pt), 32'd0);

    cycle(1, 32'h500, 1, 1, 32'h300, 1, 32'h999, 0, 0);
    chk("tp_stall_flush0", 32'(obs_flush), 32'd0);
    cycle(1, 32'h500, 0, 0, 0, 0, 0, 0, 0);
    chk("tp_stall_flush1", 32'(obs_flush), 32'd0);
    cycle(0, 32'h500, 0, 0, 0, 0, 0, 0, 0);
    chk("tp_pend_flush", 32'(obs_flush), 32'd1);
    chk("tp_pend_next", obs_next, 32'h304);
    cycle(0, 32'h504, 0, 0, 0, 0, 0, 0, 0);
    chk("tp_pend_clear", 32'(obs_flush), 32'd0);
    chk("tp_mcnt_once", obs_mcnt, 32'd4);

    cycle(0, 32'h600, 1, 1, 32'h140, 0, 0, 1, 32'h180);
    cycle(0, 32'h140, 0, 0, 0, 0, 0, 0, 0);
    chk("tp_alias_pre", 32'(obs_pt), 32'd1);
    cycle(0, 32'h140, 1, 0, 32'h140, 1, 32'h180, 0, 0);
    chk("tp_alias_flush", 32'(obs_flush), 32'd1);
    chk("tp_alias_next", obs_next, 32'h144);
    cycle(0, 32'h140, 0, 0, 0, 0, 0, 0, 0);
    chk("tp_alias_inval", 32'(obs_pt), 32'd0);

    cycle(0, 32'h600, 1, 1, 32'h108, 1, 32'h400, 1, 32'h500);
    chk("tp_tgt_flush", 32'(obs_flush), 32'd1);
    chk("tp_tgt_next", obs_next, 32'h500);
    cycle(0, 32'h108, 0, 0, 0, 0, 0, 0, 0);
    chk("tp_tgt_entry", obs_tgt, 32'h500);
    cycle(0, 32'h600, 1, 1, 32'h108, 1, 32'h500, 1, 32'h600);
    cycle(0, 32'h108, 0, 0, 0, 0, 0, 0, 0);
    chk("tp_tgt_retrain", obs_tgt, 32'h600);

    cycle(1, 32'h700, 1, 1, 32'h200, 0, 0, 1, 32'h240);
    do_reset();
    cycle(0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    chk("tp_rst_drop_flush", 32'(obs_flush), 32'd0);
    chk("tp_rst_drop_next", obs_next, 32'h104);

    for (int n = 0; n < 1500; n++) begin
      rpc = mkpc();
      rtg = mkpc();
      cycle($urandom_range(0, 9) < 3, mkpc(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0, rpc, 1'($urandom_range(0, 1)), rtg,
            1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? rtg : mkpc());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
